// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution datapath, used by the input
// layer stage and the MAC stage so both agree on window lane packing and widths.
package conv_pkg;

    localparam int PIX_W    = 8;
    localparam int ACC_W    = 21;
    localparam int PROD_W   = 2 * PIX_W + 1;
    localparam int ROWS     = 3;
    localparam int COLS     = 3;
    localparam int NUM_TAPS = ROWS * COLS;

    // Byte lane of each window pixel, row-major from the top-left tap.
    localparam int LANE_R0C0 = 0;
    localparam int LANE_R0C1 = 1;
    localparam int LANE_R0C2 = 2;
    localparam int LANE_R1C0 = 3;
    localparam int LANE_R1C1 = 4;
    localparam int LANE_R1C2 = 5;
    localparam int LANE_R2C0 = 6;
    localparam int LANE_R2C1 = 7;
    localparam int LANE_R2C2 = 8;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  sum_t;

    function automatic int lane_idx(input int row, input int col);
        return LANE_R0C0 + row * COLS + col;
    endfunction

endpackage

// File: rtl/conv3x3_adder_tree.sv
// Three-stage 3x3 MAC datapath: S1 multiply, S2 row sums, S3 bias/shift/saturate.
// Build option: define CONV3X3_RELU_EN to clamp negative results to 0 before saturation.
module conv3x3_adder_tree #(
    parameter int PIX_W = 8,
    parameter int ID_W  = 3,
    parameter int ACC_W = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_vld,
    input  logic [9*PIX_W-1:0]    pix,
    input  logic [ID_W-1:0]       in_id,
    input  logic [9*PIX_W-1:0]    wt,
    input  logic signed [15:0]    bias,
    input  logic [3:0]            shift_amt,
    output logic                  vld_p0,
    output logic                  vld_p1,
    output logic                  vld_p2,
    output logic signed [7:0]     data_p2,
    output logic [ID_W-1:0]       id_p2
);
    import conv_pkg::*;

    localparam int MUL_W = 2 * PIX_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    function automatic logic signed [7:0] requant(input logic signed [ACC_W-1:0] sum,
                                                  input logic [3:0]              sh);
        logic signed [ACC_W-1:0] v;
        v = sum >>> sh;
`ifdef CONV3X3_RELU_EN
        if (v < 0) v = '0;
`endif
        if (v > SAT_HI) return 8'h7f;
        if (v < SAT_LO) return 8'h80;
        return v[7:0];
    endfunction

    logic signed [MUL_W-1:0] prod_c  [NUM_TAPS];
    logic signed [MUL_W-1:0] prod_p0 [NUM_TAPS];
    logic signed [ACC_W-1:0] row_c   [ROWS];
    logic signed [ACC_W-1:0] row_p1  [ROWS];
    logic signed [ACC_W-1:0] sum_c;
    logic [ID_W-1:0]         id_p0;
    logic [ID_W-1:0]         id_p1;

    // S1: unsigned pixel times signed weight, per lane
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_c[k] = MUL_W'($signed({1'b0, pix[k*PIX_W +: PIX_W]}))
                      * MUL_W'($signed(wt[k*PIX_W +: PIX_W]));
        end
    end

    // S2: one partial sum per window row
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_c[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                row_c[r] = row_c[r] + ACC_W'(prod_p0[lane_idx(r, c)]);
            end
        end
    end

    // S3: final sum with bias, then requantise
    assign sum_c = row_p1[0] + row_p1[1] + row_p1[2] + ACC_W'(bias);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            id_p2   <= '0;
        end else if (en) begin
            vld_p0 <= in_vld;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= requant(sum_c, shift_amt);
                id_p2   <= id_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            prod_p0 <= prod_c;
            id_p0   <= in_id;
            row_p1  <= row_c;
            id_p1   <= id_p0;
        end
    end

endmodule

// File: rtl/conv3x3_mac_stage.sv
// 3x3 convolution MAC stage: kernel load, window/output handshakes and frame counting.
// Build option: CONV3X3_RELU_EN (applied in conv3x3_adder_tree) limits out_data to [0, 127].
module conv3x3_mac_stage #(
    parameter int PIX_W = 8,
    parameter int ID_W  = 3,
    parameter int ACC_W = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9*PIX_W-1:0]    win_data,
    input  logic                  win_valid,
    output logic                  win_rdy,
    input  logic [ID_W-1:0]       win_id,
    input  logic [9*PIX_W-1:0]    wt_data,
    input  logic                  wt_valid,
    output logic                  wt_rdy,
    input  logic signed [15:0]    bias,
    input  logic [3:0]            shift_amt,
    input  logic [15:0]           frame_windows,
    output logic signed [7:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_rdy,
    output logic [ID_W-1:0]       out_id,
    output logic                  frame_done,
    output logic                  wt_loaded
);
    import conv_pkg::*;

    logic                  pipe_en;
    logic                  wt_fire;
    logic                  win_fire;
    logic                  out_fire;
    logic                  vld_p0;
    logic                  vld_p1;
    logic [9*PIX_W-1:0]    wt_q;
    logic signed [15:0]    bias_q;
    logic [3:0]            shift_q;
    logic [15:0]           out_cnt;

    assign pipe_en  = !out_valid || out_rdy;
    assign wt_rdy   = !vld_p0 && !vld_p1 && !out_valid;
    assign wt_fire  = wt_valid && wt_rdy;
    // A kernel load claims the cycle, so a window offered alongside it is held off.
    assign win_rdy  = pipe_en && wt_loaded && !wt_fire;
    assign win_fire = win_valid && win_rdy;
    assign out_fire = out_valid && out_rdy;

    conv3x3_adder_tree #(
        .PIX_W (PIX_W),
        .ID_W  (ID_W),
        .ACC_W (ACC_W)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .en        (pipe_en),
        .in_vld    (win_fire),
        .pix       (win_data),
        .in_id     (win_id),
        .wt        (wt_q),
        .bias      (bias_q),
        .shift_amt (shift_q),
        .vld_p0    (vld_p0),
        .vld_p1    (vld_p1),
        .vld_p2    (out_valid),
        .data_p2   (out_data),
        .id_p2     (out_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wt_q      <= '0;
            bias_q    <= '0;
            shift_q   <= '0;
            wt_loaded <= 1'b0;
        end else if (wt_fire) begin
            wt_q      <= wt_data;
            bias_q    <= bias;
            shift_q   <= shift_amt;
            wt_loaded <= 1'b1;
        end
    end

    // frame_windows of zero never matches, so the counter free-runs modulo 2^16
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_fire) begin
                if (frame_windows != 16'd0 && out_cnt == frame_windows - 16'd1) begin
                    out_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    out_cnt <= out_cnt + 16'd1;
                end
            end
        end
    end

endmodule
